// File: rtl/kyber_pkg.sv
// Shared Kyber datapath constants, coefficient type and scalar-scale FSM states.
package kyber_pkg;

  localparam int unsigned KYBER_Q    = 3329;
  localparam int unsigned KYBER_N    = 128;
  localparam int unsigned BARRETT_M  = 5039;
  localparam int unsigned BARRETT_SH = 24;

  typedef logic [11:0] coef_t;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    RED,
    OUT,
    DONE
  } cscale_state_e;

endpackage

// File: rtl/mod3329_reduce.sv
// Reduces a 24-bit product modulo 3329. Default: 13-cycle restoring reduction;
// CSCALE_BARRETT_EN selects a 2-cycle Barrett reduction with identical results.
module mod3329_reduce
  import kyber_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [23:0] p_i,
  output logic        done_o,
  output coef_t       res_o
);

`ifdef CSCALE_BARRETT_EN

  logic [12:0] t;
  logic [13:0] r_d;
  logic [13:0] r_q;
  logic [13:0] s1;
  logic        busy_q;

  // t underestimates p/Q by less than 2, so r_d < 3Q and two subtracts suffice.
  always_comb begin
    t      = 13'((37'(p_i) * 37'(BARRETT_M)) >> BARRETT_SH);
    r_d    = 14'(p_i - 24'(t) * 24'(KYBER_Q));
    s1     = (r_q >= 14'(KYBER_Q)) ? r_q - 14'(KYBER_Q) : r_q;
    res_o  = (s1 >= 14'(KYBER_Q)) ? 12'(s1 - 14'(KYBER_Q)) : 12'(s1);
    done_o = busy_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      r_q    <= '0;
    end else begin
      busy_q <= start_i;
      if (start_i) begin
        r_q <= r_d;
      end
    end
  end

`else

  logic [3:0]  k_q;
  logic [3:0]  k_cur;
  logic [23:0] r_q;
  logic [23:0] r_cur;
  logic [23:0] sub;
  logic [23:0] r_nxt;
  logic        busy_q;
  logic        active;

  // The start cycle already performs the k=12 step on p_i, and the k=0 step
  // feeds res_o combinationally, so the whole reduction spans 13 cycles.
  always_comb begin
    active = start_i | busy_q;
    k_cur  = start_i ? 4'd12 : k_q;
    r_cur  = start_i ? p_i : r_q;
    sub    = 24'(KYBER_Q) << k_cur;
    r_nxt  = (r_cur >= sub) ? r_cur - sub : r_cur;
    done_o = active && (k_cur == 4'd0);
    res_o  = r_nxt[11:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      k_q    <= '0;
      r_q    <= '0;
    end else if (active) begin
      r_q    <= r_nxt;
      k_q    <= k_cur - 4'd1;
      busy_q <= (k_cur != 4'd0);
    end
  end

`endif

endmodule

// File: rtl/cscale_stream.sv
// Scalar-by-vector multiply mod 3329, streamed as one valid/ready beat per element.
// Define CSCALE_BARRETT_EN for the 4-cycle-per-element Barrett reduction path.
module cscale_stream
  import kyber_pkg::*;
#(
  parameter int unsigned N  = KYBER_N,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  coef_t             s_i,
  input  coef_t [N-1:0]     a_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output coef_t             out_data_o,
  output logic [IW-1:0]     out_idx_o
);

  cscale_state_e state_q;
  coef_t         s_q;
  logic [23:0]   p_q;
  logic          red_start_q;
  logic          red_done;
  coef_t         red_res;

  mod3329_reduce u_reduce (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (red_start_q),
    .p_i     (p_q),
    .done_o  (red_done),
    .res_o   (red_res)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      s_q         <= '0;
      p_q         <= '0;
      red_start_q <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_idx_o   <= '0;
    end else begin
      red_start_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            s_q       <= s_i;
            out_idx_o <= '0;
            busy_o    <= 1'b1;
            done_o    <= 1'b0;
            state_q   <= MUL;
          end
        end
        MUL: begin
          p_q         <= 24'(s_q) * 24'(a_i[out_idx_o]);
          red_start_q <= 1'b1;
          state_q     <= RED;
        end
        RED: begin
          if (red_done) begin
            out_data_o  <= red_res;
            out_valid_o <= 1'b1;
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            if (out_idx_o == IW'(N - 1)) begin
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
              state_q <= DONE;
            end else begin
              out_idx_o <= out_idx_o + 1'b1;
              state_q   <= MUL;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cscale_stream.sv
// Directed self-checking bench for cscale_stream (both reduction builds).
module tb_cscale_stream;
  import kyber_pkg::*;

  localparam int unsigned N  = 128;
  localparam int unsigned IW = 7;
`ifdef CSCALE_BARRETT_EN
  localparam int EL_LAT = 4;
`else
  localparam int EL_LAT = 15;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          out_ready_i = 1'b0;
  coef_t         s_i = '0;
  coef_t [N-1:0] a_i = '0;
  logic          busy_o;
  logic          done_o;
  logic          out_valid_o;
  coef_t         out_data_o;
  logic [IW-1:0] out_idx_o;

  int n_checks = 0;
  int n_fail   = 0;

  coef_t         bd[256];
  logic [IW-1:0] bi[256];
  int            bc[256];
  int            nb;
  int            stall_err;
  int            done_cyc;
  bit            tmo;

  cscale_stream #(.N(N), .IW(IW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .s_i         (s_i),
    .a_i         (a_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_idx_o   (out_idx_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_op(input coef_t s);
    @(posedge clk_i); #1;
    start_i = 1'b1;
    s_i     = s;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  // Drives out_ready_i and records accepted beats; cycle 1 is the negedge after the start-sampling edge.
  task automatic collect(input bit rnd, input int stop_at);
    int            cyc;
    bit            stalled;
    coef_t         pd;
    logic [IW-1:0] pix;
    nb = 0; stall_err = 0; done_cyc = -1; tmo = 1'b0;
    cyc = 0; stalled = 1'b0; pd = '0; pix = '0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (stalled && (!out_valid_o || out_data_o !== pd || out_idx_o !== pix)) stall_err++;
      if (done_o) begin
        done_cyc = cyc;
        break;
      end
      if (nb >= stop_at) break;
      if (cyc > 10000 || nb >= 256) begin
        tmo = 1'b1;
        break;
      end
      out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled     = out_valid_o && !out_ready_i;
      pd          = out_data_o;
      pix         = out_idx_o;
      if (out_valid_o && out_ready_i) begin
        bd[nb] = out_data_o;
        bi[nb] = out_idx_o;
        bc[nb] = cyc;
        nb++;
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done_o); end
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", out_valid_o); end
    n_checks++; if (out_data_o !== 12'd0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", out_data_o); end
    n_checks++; if (out_idx_o !== 7'd0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", out_idx_o); end
    rst_ni = 1'b1;
  endtask

  task automatic test_identity();
    for (int i = 0; i < N; i++) a_i[i] = coef_t'(i);
    start_op(12'd1);
    collect(1'b0, 1000);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL ident_timeout: got timeout expected done"); end
    n_checks++; if (nb != 128) begin n_fail++; $display("FAIL ident_count: got %0d expected 128", nb); end
    for (int k = 0; k < nb && k < 128; k++) begin
      n_checks++; if (bd[k] !== coef_t'(k)) begin n_fail++; $display("FAIL ident_data[%0d]: got %0d expected %0d", k, bd[k], k); end
      n_checks++; if (bi[k] !== IW'(k)) begin n_fail++; $display("FAIL ident_idx[%0d]: got %0d expected %0d", k, bi[k], k); end
    end
    n_checks++; if (bc[0] != EL_LAT) begin n_fail++; $display("FAIL first_latency: got %0d expected %0d", bc[0], EL_LAT); end
    n_checks++; if (bc[1] - bc[0] != EL_LAT) begin n_fail++; $display("FAIL beat_period: got %0d expected %0d", bc[1] - bc[0], EL_LAT); end
    n_checks++; if (done_cyc != 128 * EL_LAT + 1) begin n_fail++; $display("FAIL done_cycle: got %0d expected %0d", done_cyc, 128 * EL_LAT + 1); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL busy_after_done: got %0b expected 0", busy_o); end
  endtask

  task automatic test_neg_one();
    for (int i = 0; i < N; i++) a_i[i] = 12'd3328;
    start_op(12'd3328);
    collect(1'b0, 1000);
    n_checks++; if (nb != 128) begin n_fail++; $display("FAIL negone_count: got %0d expected 128", nb); end
    for (int k = 0; k < nb && k < 128; k++) begin
      n_checks++; if (bd[k] !== 12'd1) begin n_fail++; $display("FAIL negone_data[%0d]: got %0d expected 1", k, bd[k]); end
    end
  endtask

  task automatic test_max_input();
    for (int i = 0; i < N; i++) a_i[i] = 12'd4095;
    start_op(12'd4095);
    collect(1'b0, 1000);
    n_checks++; if (nb != 128) begin n_fail++; $display("FAIL max_count: got %0d expected 128", nb); end
    // 4095*4095 = 16769025 = 3329*5037 + 852
    for (int k = 0; k < nb && k < 128; k++) begin
      n_checks++; if (bd[k] !== 12'd852) begin n_fail++; $display("FAIL max_data[%0d]: got %0d expected 852", k, bd[k]); end
    end
  endtask

  task automatic test_random_ready();
    int e;
    for (int i = 0; i < N; i++) a_i[i] = coef_t'((i * 97 + 5) % 4096);
    start_op(12'd17);
    collect(1'b1, 1000);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL rr_timeout: got timeout expected done"); end
    n_checks++; if (nb != 128) begin n_fail++; $display("FAIL rr_count: got %0d expected 128", nb); end
    n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL rr_stall_stable: got %0d changes expected 0", stall_err); end
    for (int k = 0; k < nb && k < 128; k++) begin
      e = (17 * ((k * 97 + 5) % 4096)) % 3329;
      n_checks++; if (bd[k] !== coef_t'(e)) begin n_fail++; $display("FAIL rr_data[%0d]: got %0d expected %0d", k, bd[k], e); end
      n_checks++; if (bi[k] !== IW'(k)) begin n_fail++; $display("FAIL rr_idx[%0d]: got %0d expected %0d", k, bi[k], k); end
    end
    out_ready_i = 1'b1;
  endtask

  task automatic test_reset_mid();
    int e;
    for (int i = 0; i < N; i++) a_i[i] = coef_t'(i * 31);
    start_op(12'd2);
    collect(1'b0, 40);
    n_checks++; if (nb != 40) begin n_fail++; $display("FAIL mid_prefix_count: got %0d expected 40", nb); end
    n_checks++; if (bd[39] !== coef_t'(2 * 39 * 31)) begin n_fail++; $display("FAIL mid_prefix_data: got %0d expected %0d", bd[39], 2 * 39 * 31); end
    #1 rst_ni = 1'b0;
    #1;
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %0b expected 0", busy_o); end
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %0b expected 0", out_valid_o); end
    n_checks++; if (out_data_o !== 12'd0) begin n_fail++; $display("FAIL mid_rst_data: got %0d expected 0", out_data_o); end
    n_checks++; if (out_idx_o !== 7'd0) begin n_fail++; $display("FAIL mid_rst_idx: got %0d expected 0", out_idx_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    start_op(12'd5);
    collect(1'b0, 1000);
    n_checks++; if (nb != 128) begin n_fail++; $display("FAIL mid_restart_count: got %0d expected 128", nb); end
    n_checks++; if (bi[0] !== 7'd0) begin n_fail++; $display("FAIL mid_restart_idx0: got %0d expected 0", bi[0]); end
    for (int k = 0; k < nb && k < 128; k++) begin
      e = (5 * k * 31) % 3329;
      n_checks++; if (bd[k] !== coef_t'(e)) begin n_fail++; $display("FAIL mid_restart_data[%0d]: got %0d expected %0d", k, bd[k], e); end
    end
  endtask

  task automatic test_restart();
    int e;
    start_op(12'd7);
    @(posedge clk_i); #1;
    start_i = 1'b1;
    s_i     = 12'd9;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    collect(1'b0, 1000);
    n_checks++; if (nb != 128) begin n_fail++; $display("FAIL busy_start_count: got %0d expected 128", nb); end
    n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL busy_start_done: got %0b expected 1", done_o); end
    for (int k = 0; k < nb && k < 128; k++) begin
      e = (7 * k * 31) % 3329;
      n_checks++; if (bd[k] !== coef_t'(e)) begin n_fail++; $display("FAIL busy_start_data[%0d]: got %0d expected %0d", k, bd[k], e); end
    end
    start_op(12'd11);
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL restart_done_drop: got %0b expected 0", done_o); end
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL restart_busy: got %0b expected 1", busy_o); end
    collect(1'b0, 1000);
    n_checks++; if (nb != 128) begin n_fail++; $display("FAIL restart_count: got %0d expected 128", nb); end
    for (int k = 0; k < nb && k < 128; k++) begin
      e = (11 * k * 31) % 3329;
      n_checks++; if (bd[k] !== coef_t'(e)) begin n_fail++; $display("FAIL restart_data[%0d]: got %0d expected %0d", k, bd[k], e); end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_neg_one();
    test_max_input();
    test_random_ready();
    test_reset_mid();
    test_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
